// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between EX/MEM and data memory.
// Queues stores, drains one per cycle, and forwards full-word data to later loads.
module mem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 13
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_code,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_code,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_code,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [4:0] CodeSh = 5'b01001;
  localparam logic [4:0] CodeSb = 5'b00110;
  localparam logic [4:0] CodeLh = 5'b00111;
  localparam logic [4:0] CodeLb = 5'b01000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  code;
  } entryT;

  // Word index as seen by the data memory for a given access size.
  function automatic logic [IDX_W-1:0] storeIdx(input logic [31:0] addr, input logic [4:0] code);
    case (code)
      CodeSh:  storeIdx = IDX_W'(addr[11:2]);
      CodeSb:  storeIdx = IDX_W'(addr[7:0]);
      default: storeIdx = addr[IDX_W+1:2];
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] loadIndex(input logic [31:0] addr, input logic [4:0] code);
    case (code)
      CodeLh:  loadIndex = IDX_W'(addr[11:2]);
      CodeLb:  loadIndex = IDX_W'(addr[7:0]);
      default: loadIndex = addr[IDX_W+1:2];
    endcase
  endfunction

  function automatic logic isSubStore(input logic [4:0] code);
    isSubStore = (code == CodeSh) || (code == CodeSb);
  endfunction

  entryT              fifo [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic [IDX_W-1:0]   loadIdx;
  logic               loadSub;
  logic               matchAny;
  logic               youngSub;
  logic [31:0]        youngData;
  logic [PTR_W-1:0]   slot;
  logic               hit;
  logic               fullStall;
  logic               ldStall;
  logic               enq;
  logic               deq;

  assign loadIdx = loadIndex(ld_addr, ld_code);
  assign loadSub = (ld_code == CodeLh) || (ld_code == CodeLb);

  // Scan in-flight first, then head..tail-1 so the youngest match is kept last.
  always_comb begin
    matchAny  = 1'b0;
    youngSub  = 1'b0;
    youngData = '0;
    slot      = '0;
    if (ld_req) begin
      if (mem_write && (storeIdx(mem_addr, mem_code) == loadIdx)) begin
        matchAny  = 1'b1;
        youngSub  = isSubStore(mem_code);
        youngData = mem_wdata;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot = head + PTR_W'(k);
        if ((CNT_W'(k) < count) && (storeIdx(fifo[slot].addr, fifo[slot].code) == loadIdx)) begin
          matchAny  = 1'b1;
          youngSub  = isSubStore(fifo[slot].code);
          youngData = fifo[slot].data;
        end
      end
    end
  end

  assign hit       = matchAny && !youngSub && !loadSub;
  assign ldStall   = matchAny && !hit;
  assign fullStall = in_valid && (count == CNT_W'(DEPTH));
  assign stall     = fullStall || ldStall;
  assign ld_hit    = hit;
  assign ld_data   = hit ? youngData : 32'h0;
  assign enq       = in_valid && !stall;
  assign deq       = (count != '0);
  assign empty     = (count == '0) && !mem_write;

  // Pointers, occupancy and the in-flight write register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_code  <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) begin
        head      <= head + PTR_W'(1);
        mem_addr  <= fifo[head].addr;
        mem_wdata <= fifo[head].data;
        mem_code  <= fifo[head].code;
      end
      mem_write <= deq;
      count     <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (enq) fifo[tail] <= '{addr: in_addr, data: in_data, code: in_code};
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of pending and in-flight stores.
module tb_mem_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 13;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  code;
  } stT;

  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [4:0]  in_code;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [4:0]  ld_code;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        stall;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_code;
  logic        empty;

  mem_store_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .Reset(Reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_code(in_code),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_code(ld_code),
    .ld_hit(ld_hit), .ld_data(ld_data), .stall(stall),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_code(mem_code),
    .empty(empty)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  stT pendQ[$];
  stT expWr[$];
  bit infValid = 0;
  stT inf;
  stT monEntry;

  function automatic int unsigned stIdx(input logic [31:0] a, input logic [4:0] c);
    if (c == 5'b01001) return (a >> 2) & 32'h3FF;
    if (c == 5'b00110) return a & 32'hFF;
    return (a >> 2) & ((32'd1 << IDX_W) - 1);
  endfunction

  function automatic int unsigned ldIdx(input logic [31:0] a, input logic [4:0] c);
    if (c == 5'b00111) return (a >> 2) & 32'h3FF;
    if (c == 5'b01000) return a & 32'hFF;
    return (a >> 2) & ((32'd1 << IDX_W) - 1);
  endfunction

  function automatic bit subSt(input logic [4:0] c);
    return (c == 5'b01001) || (c == 5'b00110);
  endfunction

  function automatic bit subLd(input logic [4:0] c);
    return (c == 5'b00111) || (c == 5'b01000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs from the store history (oldest to youngest).
  task automatic modelComb(input bit iv, input bit lr, input logic [31:0] la, input logic [4:0] lc,
                           output bit mStall, output bit mHit, output logic [31:0] mData);
    bit found = 0;
    bit ySub = 0;
    logic [31:0] yData = 0;
    if (lr) begin
      if (infValid && stIdx(inf.addr, inf.code) == ldIdx(la, lc)) begin
        found = 1; ySub = subSt(inf.code); yData = inf.data;
      end
      foreach (pendQ[i]) begin
        if (stIdx(pendQ[i].addr, pendQ[i].code) == ldIdx(la, lc)) begin
          found = 1; ySub = subSt(pendQ[i].code); yData = pendQ[i].data;
        end
      end
    end
    mHit   = found && !ySub && !subLd(lc);
    mStall = (iv && pendQ.size() == DEPTH) || (found && !mHit);
    mData  = mHit ? yData : 32'h0;
  endtask

  task automatic cycle(input bit iv, input logic [31:0] a, input logic [31:0] d, input logic [4:0] c,
                       input bit lr, input logic [31:0] la, input logic [4:0] lc, output bit stalled);
    bit mStall, mHit;
    logic [31:0] mData;
    stT s;
    @(negedge clk);
    in_valid = iv; in_addr = a; in_data = d; in_code = c;
    ld_req = lr; ld_addr = la; ld_code = lc;
    modelComb(iv, lr, la, lc, mStall, mHit, mData);
    #1;
    check("stall", 32'(stall), 32'(mStall));
    check("ld_hit", 32'(ld_hit), 32'(mHit));
    check("ld_data", ld_data, mData);
    check("empty", 32'(empty), 32'(pendQ.size() == 0 && !infValid));
    check("mem_write", 32'(mem_write), 32'(infValid));
    @(posedge clk);
    if (pendQ.size() > 0) begin
      inf = pendQ.pop_front();
      infValid = 1;
    end else begin
      infValid = 0;
    end
    if (iv && !mStall) begin
      s.addr = a; s.data = d; s.code = c;
      pendQ.push_back(s);
      expWr.push_back(s);
    end
    stalled = mStall;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [4:0] c);
    bit st;
    for (int n = 0; n < 20; n++) begin
      cycle(1, a, d, c, 0, 0, 0, st);
      if (!st) return;
    end
    nTests++; nFail++;
    $display("FAIL store_hold: stall never cleared for addr %h", a);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] c);
    bit st;
    for (int n = 0; n < 20; n++) begin
      cycle(0, 0, 0, 0, 1, a, c, st);
      if (!st) return;
    end
    nTests++; nFail++;
    $display("FAIL load_hold: stall never cleared for addr %h", a);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, st);
  endtask

  // Monitor: every memory write must match the oldest accepted store.
  always @(negedge clk) begin
    if (Reset === 1'b1 && mem_write === 1'b1) begin
      if (expWr.size() == 0) begin
        nTests++; nFail++;
        $display("FAIL unexpected_write: addr %h data %h with nothing pending", mem_addr, mem_wdata);
      end else begin
        monEntry = expWr.pop_front();
        check("wr_addr", mem_addr, monEntry.addr);
        check("wr_data", mem_wdata, monEntry.data);
        check("wr_code", 32'(mem_code), 32'(monEntry.code));
      end
    end
  end

  logic [4:0] stCodes [4];
  logic [4:0] ldCodes [4];

  initial begin
    bit st;
    int kind;
    logic [31:0] a, d;
    logic [4:0] c;
    stCodes[0] = 5'b00000; stCodes[1] = 5'b01001; stCodes[2] = 5'b00110; stCodes[3] = 5'b11111;
    ldCodes[0] = 5'b00000; ldCodes[1] = 5'b00111; ldCodes[2] = 5'b01000; ldCodes[3] = 5'b00010;

    Reset = 1'b0;
    in_valid = 0; in_addr = 0; in_data = 0; in_code = 0;
    ld_req = 0; ld_addr = 0; ld_code = 0;
    #12;
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_code", 32'(mem_code), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ld_hit", 32'(ld_hit), 32'h0);
    @(negedge clk);
    Reset = 1'b1;

    // Single store latency
    store(32'h40, 32'hDEADBEEF, 5'b00000);
    idle(3);

    // Back-to-back stores
    for (int i = 0; i < 6; i++) store(32'(i * 4), $urandom, 5'b00000);
    idle(3);

    // Forwarding from the youngest full-word store
    store(32'h100, 32'h11111111, 5'b00000);
    store(32'h100, 32'h22222222, 5'b00000);
    load(32'h100, 5'b00000);
    idle(3);

    // Partial overlap forces a stall until the byte store leaves
    store(32'h08, 32'h000000AB, 5'b00110);
    load(32'h08, 5'b01000);
    idle(3);

    // Wrap-around with idle gaps; forward from the 9th store
    for (int i = 0; i < 8; i++) begin
      store(32'h300 + 32'(i * 4), 32'hA0000000 + 32'(i), 5'b00000);
      idle(1);
    end
    store(32'h400, 32'h99999999, 5'b00000);
    load(32'h400, 5'b00000);
    store(32'h404, 32'hAAAA000A, 5'b00000);
    idle(3);

    // Reset with stores queued and in flight
    store(32'h200, 32'h1, 5'b00000);
    store(32'h204, 32'h2, 5'b00000);
    store(32'h208, 32'h3, 5'b00000);
    #2;
    Reset = 1'b0;
    in_valid = 0; ld_req = 0;
    pendQ.delete();
    expWr.delete();
    infValid = 0;
    #1;
    check("midrst_mem_write", 32'(mem_write), 32'h0);
    check("midrst_empty", 32'(empty), 32'h1);
    @(negedge clk);
    Reset = 1'b1;
    idle(5);

    // Randomized traffic with aliasing addresses; stalled instructions are held
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) << 15) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      d = $urandom;
      if (kind <= 3) begin
        store(a, d, stCodes[$urandom_range(0, 3)]);
      end else if (kind <= 6) begin
        load(a, ldCodes[$urandom_range(0, 3)]);
      end else if (kind <= 8) begin
        idle(1);
      end else begin
        c = stCodes[$urandom_range(0, 3)];
        for (int h = 0; h < 20; h++) begin
          cycle(1, a, d, c, 1, a, ldCodes[$urandom_range(0, 3)], st);
          if (!st) break;
        end
      end
    end
    idle(4);
    check("all_writes_drained", 32'(expWr.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Posted-write buffer between the EX/MEM pipeline register and the data memory.
- Queues stores (sw/sh/sb) from the MEM stage in a small FIFO and retires one per cycle to the memory write port, so stores never hold up the pipeline until the buffer is full.
- Forwards buffered full-word store data to later lw instructions.
- Requests a stall when a load partially overlaps a pending store or the buffer is full.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- IDX_W, 13, memory word-index width (8192-word data memory).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  store present in MEM stage (MemWrite).
- in_addr  in  32  store byte address.
- in_data  in  32  store data.
- in_code  in  5  aluCode of store: 01001 = sh, 00110 = sb, anything else = sw.
- ld_req  in  1  load present in MEM stage (MemRead).
- ld_addr  in  32  load byte address.
- ld_code  in  5  aluCode of load: 00111 = lh, 01000 = lb, anything else = lw.
- ld_hit  out  1  load data is supplied from the buffer (combinational).
- ld_data  out  32  forwarded data, valid when ld_hit is 1, else 0.
- stall  out  1  freeze MEM stage and upstream this cycle (combinational).
- mem_write  out  1  registered write strobe to data memory.
- mem_addr  out  32  registered write address.
- mem_wdata  out  32  registered write data.
- mem_code  out  5  registered aluCode passed to memory with the write.
- empty  out  1  no queued entry and no write in flight.

Behaviour:
- Reset (async, Reset=0): head, tail and count cleared; mem_write=0; mem_addr, mem_wdata, mem_code = 0. Combinational outputs follow their equations, so ld_hit=0, ld_data=0, stall=0 and empty=1 while inputs are idle.
- Reset asserted mid-operation discards all queued and in-flight stores. The memory sees no write after reset assertion.
- Enqueue: at posedge when in_valid=1 and stall=0, write {in_addr, in_data, in_code} at tail, tail++ (wraps mod DEPTH).
- Drain: at posedge when count>0, register the head entry onto mem_*, set mem_write=1 and head++. Otherwise mem_write=0. Each mem_write pulse is exactly one cycle per entry; the memory commits it on the following negedge.
- Latency: a store accepted at edge E appears on mem_* with mem_write=1 after edge E+1 (when the buffer was empty). Throughput is one entry per cycle.
- Simultaneous enqueue and drain: count unchanged. Enqueue into a full buffer never happens in the same cycle as a drain.
- Full: stall = in_valid AND count==DEPTH. This is conservative; the slot freed by a same-cycle drain is not used. in_valid held by the pipeline is accepted on the next cycle.
- Index function (matches the memory's addressing):
  - sw/lw: addr[14:2].
  - sh/lh: addr[11:2], zero-extended to IDX_W.
  - sb/lb: addr[7:0], zero-extended to IDX_W.
- Load lookup, when ld_req=1: compare the load index against every valid FIFO entry plus the in-flight mem_* entry when mem_write=1. The youngest match wins; order is tail-1 down to head, then in-flight.
  - Youngest match is sw and load is lw: ld_hit=1, ld_data = entry data, stall=0.
  - Any match where the load or the youngest matching store is sub-word: stall=1, ld_hit=0, held until no matching entry remains.
  - No match: ld_hit=0, stall=0, memory supplies the data.
- ld_req and in_valid are mutually exclusive (one instruction in MEM). If both are asserted, lookup ignores the incoming store and stall = OR of both stall terms.
- Index arithmetic is unsigned and compares exactly IDX_W bits; addr bits above the index are ignored.
- empty = (count==0) AND (mem_write==0).

Test Plan:
- Reset with entries queued:
  - Stimulus: three sw queued, Reset=0 between edges.
  - Required: mem_write=0 immediately, empty=1, and no later write reaches mem_*.
- Single store latency:
  - Stimulus: sw addr 0x40, data 0xDEADBEEF, in_valid for one cycle.
  - Required: mem_write=1 one cycle later with mem_addr=0x40, mem_wdata=0xDEADBEEF, mem_code=00000; then empty=1.
- Full buffer:
  - Stimulus: in_valid held for 6 back-to-back sw, addr 0x0, 0x4, ... 0x14.
  - Required: no stall while count<4; memory receives all six writes in order, one per cycle; zero writes lost or duplicated.
- Forwarding:
  - Stimulus: sw 0x100 = 0x11111111, then sw 0x100 = 0x22222222, then lw 0x100 next cycle.
  - Required: ld_hit=1, ld_data=0x22222222, stall=0.
- Partial overlap:
  - Stimulus: sb addr 0x08, data 0xAB, then lb addr 0x08 the next cycle.
  - Required: stall=1 until the sb write has left the in-flight register; then ld_hit=0 and stall=0.
- Wrap-around:
  - Stimulus: 10 stores with interleaved idle cycles.
  - Required: head and tail wrap correctly; the mem_* sequence equals the input order; an lw to the 9th store's address forwards its data.
